instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/rv32i_pkg.sv | 65 ++++++
 rtl/enc_fifo2.sv | 65 ++++++
 rtl/instr_encoder.sv | 62 ++++++
 tb/tb_instr_encoder.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: instruction-type enum, major opcodes and the
// combinational encoder that turns an instruction description into a
// 32-bit word plus an illegal-type flag.
package rv32i_pkg;

   typedef enum logic [3:0] {
      IT_R     = 4'd0,
      IT_LW    = 4'd1,
      IT_ADDI  = 4'd2,
      IT_JALR  = 4'd3,
      IT_S     = 4'd4,
      IT_SB    = 4'd5,
      IT_AUIPC = 4'd6,
      IT_LUI   = 4'd7,
      IT_UJ    = 4'd8
   } itype_e;

   localparam logic [6:0] OP_R     = 7'h33;
   localparam logic [6:0] OP_LW    = 7'h03;
   localparam logic [6:0] OP_ADDI  = 7'h13;
   localparam logic [6:0] OP_JALR  = 7'h67;
   localparam logic [6:0] OP_S     = 7'h23;
   localparam logic [6:0] OP_SB    = 7'h63;
   localparam logic [6:0] OP_AUIPC = 7'h17;
   localparam logic [6:0] OP_LUI   = 7'h37;
   localparam logic [6:0] OP_UJ    = 7'h6F;

   localparam logic [31:0] NOP_WORD = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] instr;
      logic        err;
   } enc_word_t;

   // imm is in byte-offset form; branch/jump immediates drop bit 0.
   function automatic enc_word_t encode(input logic [3:0]  itype,
                                        input logic [4:0]  rd,
                                        input logic [4:0]  rs1,
                                        input logic [4:0]  rs2,
                                        input logic [2:0]  funct3,
                                        input logic [6:0]  funct7,
                                        input logic [31:0] imm);
      enc_word_t w;
      w.instr = NOP_WORD;
      w.err   = 1'b0;
      case (itype_e'(itype))
         IT_R:     w.instr = {funct7, rs2, rs1, funct3, rd, OP_R};
         IT_LW:    w.instr = {imm[11:0], rs1, funct3, rd, OP_LW};
         IT_ADDI:  w.instr = {imm[11:0], rs1, funct3, rd, OP_ADDI};
         IT_JALR:  w.instr = {imm[11:0], rs1, funct3, rd, OP_JALR};
         IT_S:     w.instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_S};
         IT_SB:    w.instr = {imm[12], imm[10:5], rs2, rs1, funct3,
                              imm[4:1], imm[11], OP_SB};
         IT_AUIPC: w.instr = {imm[31:12], rd, OP_AUIPC};
         IT_LUI:   w.instr = {imm[31:12], rd, OP_LUI};
         IT_UJ:    w.instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_UJ};
         default: begin
            w.instr = NOP_WORD;
            w.err   = 1'b1;
         end
      endcase
      return w;
   endfunction

endpackage

// File: rtl/enc_fifo2.sv
// Two-entry FIFO with valid/ready on both sides.
// Ports: clk, rst (async, active-high); push_valid/push_ready/push_data;
// pop_valid/pop_ready/pop_data. push_ready is "not full" (and low in reset),
// never a function of pop_ready. pop_data reads zero when empty.
module enc_fifo2 #(
   parameter int unsigned WIDTH = 33
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_valid,
   output logic             push_ready,
   input  logic [WIDTH-1:0] push_data,
   output logic             pop_valid,
   input  logic             pop_ready,
   output logic [WIDTH-1:0] pop_data
);

   logic [WIDTH-1:0] mem_q [2];
   logic [WIDTH-1:0] mem_d [2];
   logic             wr_ptr_q, wr_ptr_d;
   logic             rd_ptr_q, rd_ptr_d;
   logic [1:0]       count_q, count_d;
   logic             full, push, pop;

   assign full       = (count_q == 2'd2);
   assign push_ready = ~rst & ~full;
   assign pop_valid  = (count_q != 2'd0);
   assign pop_data   = pop_valid ? mem_q[rd_ptr_q] : '0;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      push     = push_valid & push_ready;
      pop      = pop_valid & pop_ready;
      if (push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/instr_encoder.sv
// RV32I instruction encoder with a 2-deep output buffer.
// Ports: clk, rst (async, active-high); in_valid/in_ready with itype, rd,
// rs1, rs2, funct3, funct7, imm describing the instruction; out_valid/
// out_ready with the encoded instr and its err flag; err_count is a
// saturating count of accepted illegal requests.
module instr_encoder (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  itype,
   input  logic [4:0]  rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [2:0]  funct3,
   input  logic [6:0]  funct7,
   input  logic [31:0] imm,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] instr,
   output logic        err,
   output logic [7:0]  err_count
);
   import rv32i_pkg::*;

   enc_word_t enc_word;
   enc_word_t out_word;
   logic [7:0] err_count_q, err_count_d;

   assign enc_word = encode(itype, rd, rs1, rs2, funct3, funct7, imm);

   enc_fifo2 #(.WIDTH($bits(enc_word_t))) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push_valid (in_valid),
      .push_ready (in_ready),
      .push_data  (enc_word),
      .pop_valid  (out_valid),
      .pop_ready  (out_ready),
      .pop_data   (out_word)
   );

   assign instr     = out_word.instr;
   assign err       = out_word.err;
   assign err_count = err_count_q;

   always_comb begin
      err_count_d = err_count_q;
      if (in_valid && in_ready && enc_word.err && (err_count_q != 8'hFF)) begin
         err_count_d = err_count_q + 8'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_count_q <= '0;
      end else begin
         err_count_q <= err_count_d;
      end
   end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: the driver queues the expected
// {instr, err} when a request is accepted; the monitor pops and compares
// whenever a word is handed over.
module tb_instr_encoder;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  itype;
   logic [4:0]  rd, rs1, rs2;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [31:0] imm;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] instr;
   logic        err;
   logic [7:0]  err_count;

   int n_tests = 0;
   int n_fail  = 0;
   logic [32:0] sb_q[$];

   instr_encoder dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .itype     (itype),
      .rd        (rd),
      .rs1       (rs1),
      .rs2       (rs2),
      .funct3    (funct3),
      .funct7    (funct7),
      .imm       (imm),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .instr     (instr),
      .err       (err),
      .err_count (err_count)
   );

   always #5 clk = ~clk;

   int unsigned cycle = 0;
   always @(posedge clk) cycle <= cycle + 1;

   task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] t, input logic [4:0] d, input logic [4:0] s1,
                        input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] im);
      in_valid = 1'b1;
      itype    = t;
      rd       = d;
      rs1      = s1;
      rs2      = s2;
      funct3   = f3;
      funct7   = f7;
      imm      = im;
   endtask

   // Waits (bounded) for acceptance, queues the expected word, then drops in_valid.
   task automatic wait_accept(input logic [31:0] exp_instr, input logic exp_err);
      bit ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (in_ready) begin
            sb_q.push_back({exp_instr, exp_err});
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         n_tests++;
         n_fail++;
         $display("FAIL accept_timeout: in_ready stayed 0, expected word 0x%0h", exp_instr);
      end
      sync();
      in_valid = 1'b0;
   endtask

   task automatic send(input logic [3:0] t, input logic [4:0] d, input logic [4:0] s1,
                       input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] im, input logic [31:0] exp_instr, input logic exp_err);
      drive(t, d, s1, s2, f3, f7, im);
      wait_accept(exp_instr, exp_err);
   endtask

   task automatic drain();
      for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(negedge clk);
      if (sb_q.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain_timeout: %0d words still expected, 0 left required", sb_q.size());
         sb_q.delete();
      end
      sync();
   endtask

   // Monitor: a handover happens at the next rising edge when both are high.
   initial begin
      logic [32:0] exp;
      forever begin
         @(negedge clk);
         if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL sb_underflow: got word 0x%0h err=%0b, expected none", instr, err);
            end else begin
               exp = sb_q.pop_front();
               check("sb_word", {instr, err}, exp);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int unsigned t0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      itype = '0; rd = '0; rs1 = '0; rs2 = '0; funct3 = '0; funct7 = '0; imm = '0;

      // Reset state
      #12;
      check("rst_out_valid", {32'd0, out_valid}, 33'd0);
      check("rst_in_ready",  {32'd0, in_ready},  33'd0);
      check("rst_instr",     {instr, err},       33'd0);
      check("rst_err_count", {25'd0, err_count}, 33'd0);
      sync();
      rst = 1'b0;
      @(negedge clk);
      check("in_ready_after_rst", {32'd0, in_ready}, 33'd1);
      sync();

      // One-cycle latency
      send(4'd2, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h0050_0093, 1'b0);
      check("latency_valid", {32'd0, out_valid}, 33'd1);
      check("latency_word",  {instr, err}, {32'h0050_0093, 1'b0});
      out_ready = 1'b1;
      drain();

      // Encodings, back to back
      send(4'd2, 5'd1,  5'd0, 5'd31, 3'd0, 7'h7F, 32'd5,          32'h0050_0093, 1'b0);
      send(4'd0, 5'd3,  5'd1, 5'd2,  3'd0, 7'd0,  32'd0,          32'h0020_81B3, 1'b0);
      send(4'd4, 5'd0,  5'd1, 5'd2,  3'd2, 7'd0,  32'd8,          32'h0020_A423, 1'b0);
      send(4'd5, 5'd0,  5'd1, 5'd2,  3'd0, 7'd0,  32'd8,          32'h0020_8463, 1'b0);
      send(4'd8, 5'd1,  5'd0, 5'd0,  3'd0, 7'd0,  32'd16,         32'h0100_00EF, 1'b0);
      send(4'd7, 5'd5,  5'd0, 5'd0,  3'd0, 7'd0,  32'h1234_5000,  32'h1234_52B7, 1'b0);
      send(4'd1, 5'd2,  5'd3, 5'd0,  3'd2, 7'd0,  32'd4,          32'h0041_A103, 1'b0);
      send(4'd3, 5'd1,  5'd2, 5'd0,  3'd0, 7'd0,  32'h0000_0FFC,  32'hFFC1_00E7, 1'b0);
      send(4'd6, 5'd1,  5'd0, 5'd0,  3'd0, 7'd0,  32'h0000_1000,  32'h0000_1097, 1'b0);
      send(4'd5, 5'd0,  5'd0, 5'd0,  3'd1, 7'd0,  32'hFFFF_FFFC,  32'hFE00_1EE3, 1'b0);
      send(4'd8, 5'd0,  5'd0, 5'd0,  3'd0, 7'd0,  32'h0000_0801,  32'h0010_006F, 1'b0);
      drain();

      // Throughput: four words in four cycles with out_ready high
      t0 = cycle;
      for (int i = 0; i < 4; i++)
         send(4'd2, 5'(i + 1), 5'd0, 5'd0, 3'd0, 7'd0, 32'(i), {12'(i), 5'd0, 3'd0, 5'(i + 1), 7'h13}, 1'b0);
      check("throughput_cycles", 33'(cycle - t0), 33'd4);
      drain();

      // Backpressure: two accepted, third refused, head word held
      out_ready = 1'b0;
      send(4'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 32'h0020_81B3, 1'b0);
      send(4'd4, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 32'h0020_A423, 1'b0);
      drive(4'd7, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("full_in_ready", {32'd0, in_ready}, 33'd0);
         check("hold_word", {instr, err}, {32'h0020_81B3, 1'b0});
      end
      sync();
      out_ready = 1'b1;
      @(negedge clk);
      check("full_no_push", {32'd0, in_ready}, 33'd0);
      wait_accept(32'h1234_52B7, 1'b0);
      drain();

      // Illegal itype, saturating error count
      send(4'd12, 5'd1, 5'd2, 5'd3, 3'd4, 7'd5, 32'hFFFF_FFFF, 32'h0000_0013, 1'b1);
      check("err_count_one", {25'd0, err_count}, 33'd1);
      for (int i = 0; i < 299; i++)
         send(4'd12, 5'd1, 5'd2, 5'd3, 3'd4, 7'd5, 32'hFFFF_FFFF, 32'h0000_0013, 1'b1);
      drain();
      check("err_count_sat", {25'd0, err_count}, 33'd255);

      // Reset with two words buffered
      out_ready = 1'b0;
      send(4'd2, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h0050_0093, 1'b0);
      send(4'd2, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd6, 32'h0060_0113, 1'b0);
      check("pre_rst_valid", {32'd0, out_valid}, 33'd1);
      rst = 1'b1;
      #1;
      sb_q.delete();
      check("mid_rst_out_valid", {32'd0, out_valid}, 33'd0);
      check("mid_rst_err_count", {25'd0, err_count}, 33'd0);
      check("mid_rst_word",      {instr, err},       33'd0);
      check("mid_rst_in_ready",  {32'd0, in_ready},  33'd0);
      sync();
      rst = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("no_stale_word", {32'd0, out_valid}, 33'd0);
      end
      sync();
      send(4'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 32'h0020_81B3, 1'b0);
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
